// File: rtl/sensor_op_sched_if.sv
// Bundle of every signal that sensor_op_sched exchanges with its neighbours.
//   command side : data_rdy, sensor_num, op_code, data_in -> scheduler; cmd_full back
//   sensor side  : sensor_req, sensor_op, sensor_wdata -> sensors; sensor_ack, sensor_rdata back
//   response side: resp_valid, resp_sensor, resp_op, resp_data, resp_err -> consumer; resp_ready back
//   status       : busy, drop_cnt
// The slave modport belongs to the scheduler. The master modport belongs to whatever
// drives it: the surrounding logic, or a testbench.
interface sensor_op_sched_if;
  logic        data_rdy;
  logic [1:0]  sensor_num;
  logic [2:0]  op_code;
  logic [15:0] data_in;
  logic        cmd_full;
  logic [3:0]  sensor_req;
  logic [2:0]  sensor_op;
  logic [15:0] sensor_wdata;
  logic [3:0]  sensor_ack;
  logic [15:0] sensor_rdata;
  logic        resp_valid;
  logic [1:0]  resp_sensor;
  logic [2:0]  resp_op;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        resp_ready;
  logic        busy;
  logic [7:0]  drop_cnt;

  modport master (
    output data_rdy, sensor_num, op_code, data_in, sensor_ack, sensor_rdata, resp_ready,
    input  cmd_full, sensor_req, sensor_op, sensor_wdata, resp_valid, resp_sensor,
           resp_op, resp_data, resp_err, busy, drop_cnt
  );

  modport slave (
    input  data_rdy, sensor_num, op_code, data_in, sensor_ack, sensor_rdata, resp_ready,
    output cmd_full, sensor_req, sensor_op, sensor_wdata, resp_valid, resp_sensor,
           resp_op, resp_data, resp_err, busy, drop_cnt
  );
endinterface

// File: rtl/sensor_op_sched.sv
// Command scheduler between decode_op and the four tag sensors.
// Decoded operations are buffered in a DEPTH-entry FIFO. Commands are issued one at a time
// to the addressed sensor over req/ack, and a request that gets no ack within TIMEOUT cycles
// fails. Each result, or an error, goes back over a valid/ready response handshake.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sensor_op_sched_if.slave (command, sensor and response channels plus status)
//
// state | meaning
// IDLE  | no command in flight; pops the FIFO head when one is queued
// REQ   | sensor_req asserted to the addressed sensor, timer running
// RESP  | response held on resp_* until resp_ready
module sensor_op_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic              clock,
  input logic              reset,
  sensor_op_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [1:0]  sensor;
    logic [2:0]  op;
    logic [15:0] data;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          fifo_mem [DEPTH];
  cmd_t          head, cmd_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   timer_q;
  logic          data_rdy_q;
  logic          strobe, push, pop, drop, ack_hit, timed_out;
  logic [1:0]    sensor_d;

  logic [3:0]    sensor_req_q;
  logic          resp_valid_q, resp_err_q, cmd_full_q, busy_q;
  logic [1:0]    resp_sensor_q;
  logic [2:0]    resp_op_q;
  logic [15:0]   resp_data_q;
  logic [7:0]    drop_cnt_q;

  assign head      = fifo_mem[rd_ptr];
  assign strobe    = bus.data_rdy & ~data_rdy_q;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  // A pop on the same edge frees a slot, so a full FIFO can still take the new entry.
  assign push      = strobe && (bus.op_code != 3'b000) && ((count_q < CW'(DEPTH)) || pop);
  assign drop      = strobe && (bus.op_code != 3'b000) && !push;
  assign ack_hit   = bus.sensor_ack[cmd_q.sensor];
  assign timed_out = (timer_q == 16'(TIMEOUT - 1));
  assign count_d   = count_q + CW'(push) - CW'(pop);
  // The sensor addressed after this edge: the newly popped head, or the current command.
  assign sensor_d  = pop ? head.sensor : cmd_q.sensor;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = REQ;
      REQ:     if (ack_hit || timed_out) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The storage array has no reset. Entries are only read after a push has written them.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{sensor: bus.sensor_num, op: bus.op_code, data: bus.data_in};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      data_rdy_q    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      cmd_q         <= '0;
      sensor_req_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_sensor_q <= '0;
      resp_op_q     <= '0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      cmd_full_q    <= 1'b0;
      busy_q        <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_rdy_q <= bus.data_rdy;
      count_q    <= count_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        cmd_q  <= head;
      end
      if (pop) timer_q <= '0;
      else if (state_q == REQ && !ack_hit && !timed_out) timer_q <= timer_q + 16'd1;
      // An ack takes priority over a timeout that lands on the same edge.
      if (state_q == REQ && state_d == RESP) begin
        resp_sensor_q <= cmd_q.sensor;
        resp_op_q     <= cmd_q.op;
        resp_data_q   <= ack_hit ? bus.sensor_rdata : 16'h0000;
        resp_err_q    <= !ack_hit;
      end
      sensor_req_q <= (state_d == REQ) ? (4'b0001 << sensor_d) : 4'b0000;
      resp_valid_q <= (state_d == RESP);
      cmd_full_q   <= (count_d == CW'(DEPTH));
      busy_q       <= (state_d != IDLE) || (count_d != '0);
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.sensor_req   = sensor_req_q;
  assign bus.sensor_op    = cmd_q.op;
  assign bus.sensor_wdata = cmd_q.data;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_sensor  = resp_sensor_q;
  assign bus.resp_op      = resp_op_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.cmd_full     = cmd_full_q;
  assign bus.busy         = busy_q;
  assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_sensor_op_sched.sv
module tb_sensor_op_sched;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sensor_op_sched_if bus();

  sensor_op_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of pending commands plus one in-flight command.
  // phase 0 = nothing in flight, 1 = waiting on the sensor, 2 = response pending.
  typedef struct {
    logic [1:0]  sensor;
    logic [2:0]  op;
    logic [15:0] data;
  } cmd_s;

  cmd_s        q[$];
  cmd_s        cur;
  cmd_s        nc;
  int          phase = 0;
  int          waited = 0;
  int          sz;
  bit          prev_rdy = 1'b0;
  bit          stb, popping;
  logic [7:0]  m_drops = '0;
  logic [2:0]  m_sop = '0;
  logic [15:0] m_swd = '0;
  logic [1:0]  m_rs = '0;
  logic [2:0]  m_rop = '0;
  logic [15:0] m_rd = '0;
  logic        m_err = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      phase = 0; waited = 0; prev_rdy = 1'b0; m_drops = '0;
      m_sop = '0; m_swd = '0; m_rs = '0; m_rop = '0; m_rd = '0; m_err = 1'b0;
      cur.sensor = '0; cur.op = '0; cur.data = '0;
    end else begin
      stb = bus.data_rdy && !prev_rdy;
      prev_rdy = bus.data_rdy;
      sz = q.size();
      popping = (phase == 0) && (sz > 0);
      if (phase == 0) begin
        if (popping) begin
          cur = q.pop_front();
          phase = 1; waited = 0;
          m_sop = cur.op; m_swd = cur.data;
        end
      end else if (phase == 1) begin
        waited++;
        if (bus.sensor_ack[cur.sensor]) begin
          phase = 2; m_rs = cur.sensor; m_rop = cur.op; m_rd = bus.sensor_rdata; m_err = 1'b0;
        end else if (waited == TIMEOUT) begin
          phase = 2; m_rs = cur.sensor; m_rop = cur.op; m_rd = 16'h0000; m_err = 1'b1;
        end
      end else begin
        if (bus.resp_ready) phase = 0;
      end
      if (stb && bus.op_code != 3'b000) begin
        if (sz < DEPTH || popping) begin
          nc.sensor = bus.sensor_num; nc.op = bus.op_code; nc.data = bus.data_in;
          q.push_back(nc);
        end else if (m_drops != 8'hFF) begin
          m_drops = m_drops + 8'd1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("sensor_req",   32'(bus.sensor_req),   (phase == 1) ? 32'(4'b0001 << cur.sensor) : 32'h0);
      chk("sensor_op",    32'(bus.sensor_op),    32'(m_sop));
      chk("sensor_wdata", 32'(bus.sensor_wdata), 32'(m_swd));
      chk("resp_valid",   32'(bus.resp_valid),   (phase == 2) ? 32'h1 : 32'h0);
      chk("resp_sensor",  32'(bus.resp_sensor),  32'(m_rs));
      chk("resp_op",      32'(bus.resp_op),      32'(m_rop));
      chk("resp_data",    32'(bus.resp_data),    32'(m_rd));
      chk("resp_err",     32'(bus.resp_err),     32'(m_err));
      chk("cmd_full",     32'(bus.cmd_full),     (q.size() == DEPTH) ? 32'h1 : 32'h0);
      chk("busy",         32'(bus.busy),         (phase != 0 || q.size() != 0) ? 32'h1 : 32'h0);
      chk("drop_cnt",     32'(bus.drop_cnt),     32'(m_drops));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.data_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [2:0] op, input logic [15:0] d);
    bus.sensor_num = s; bus.op_code = op; bus.data_in = d;
    bus.data_rdy = 1'b1;
    tick();
    bus.data_rdy = 1'b0;
    tick();
  endtask

  task automatic wait_req(input string name, input int max);
    int n = 0;
    while (bus.sensor_req == 4'b0000 && n < max) begin
      tick();
      n++;
    end
    chk(name, (n < max) ? 32'h1 : 32'h0, 32'h1);
  endtask

  logic [2:0]  r_op  [5];
  logic        r_err [5];
  logic [15:0] r_dat [5];

  initial begin
    int n, got, bad;
    bus.data_rdy = 1'b0; bus.sensor_num = '0; bus.op_code = '0; bus.data_in = '0;
    bus.sensor_ack = '0; bus.sensor_rdata = '0; bus.resp_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    reset_dut();

    // Single read: sensor 2 acks after three request cycles.
    send(2'd2, 3'd1, 16'h0005);
    wait_req("rd_wait_req", 20);
    chk("rd_req_c1", 32'(bus.sensor_req), 32'h4); tick();
    chk("rd_req_c2", 32'(bus.sensor_req), 32'h4); tick();
    chk("rd_req_c3", 32'(bus.sensor_req), 32'h4);
    chk("rd_wdata", 32'(bus.sensor_wdata), 32'h0005);
    bus.sensor_ack = 4'b0100; bus.sensor_rdata = 16'hBEEF;
    tick();
    bus.sensor_ack = 4'b0000;
    chk("rd_req_off", 32'(bus.sensor_req), 32'h0);
    chk("rd_valid", 32'(bus.resp_valid), 32'h1);
    chk("rd_sensor", 32'(bus.resp_sensor), 32'h2);
    chk("rd_op", 32'(bus.resp_op), 32'h1);
    chk("rd_data", 32'(bus.resp_data), 32'hBEEF);
    chk("rd_err", 32'(bus.resp_err), 32'h0);
    tick(); tick();

    // Timeout: no ack for sensor 1.
    send(2'd1, 3'd2, 16'h0011);
    wait_req("to_wait_req", 20);
    n = 0;
    while (bus.sensor_req == 4'b0010 && n < 50) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'(TIMEOUT));
    chk("to_valid", 32'(bus.resp_valid), 32'h1);
    chk("to_err", 32'(bus.resp_err), 32'h1);
    chk("to_data", 32'(bus.resp_data), 32'h0);
    chk("to_sensor", 32'(bus.resp_sensor), 32'h1);
    tick(); tick();

    // Overflow: first command times out and stalls in its response, the rest fill the FIFO.
    reset_dut();
    bus.resp_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(2'(i % 4), 3'(i), 16'(i * 273));
    chk("ovf_full", 32'(bus.cmd_full), 32'h1);
    chk("ovf_drops", 32'(bus.drop_cnt), 32'h2);
    chk("ovf_busy", 32'(bus.busy), 32'h1);
    bus.resp_ready = 1'b1; bus.sensor_ack = 4'hF; bus.sensor_rdata = 16'h5A5A;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (bus.resp_valid) begin
        r_op[got] = bus.resp_op; r_err[got] = bus.resp_err; r_dat[got] = bus.resp_data;
        got++;
      end
      tick();
    end
    bus.sensor_ack = 4'h0;
    chk("ovf_resp_count", 32'(got), 32'h5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovf_op%0d", k), 32'(r_op[k]), 32'(k + 1));
      chk($sformatf("ovf_err%0d", k), 32'(r_err[k]), (k == 0) ? 32'h1 : 32'h0);
      chk($sformatf("ovf_data%0d", k), 32'(r_dat[k]), (k == 0) ? 32'h0 : 32'h5A5A);
    end
    tick(); tick();

    // Strobe qualification: a long data_rdy pulse enqueues once; op 0 is ignored.
    reset_dut();
    bus.resp_ready = 1'b1; bus.sensor_ack = 4'hF;
    bus.sensor_num = 2'd3; bus.op_code = 3'd2; bus.data_in = 16'h0077;
    bus.data_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) bus.data_rdy = 1'b0;
      tick();
      if (bus.resp_valid) got++;
    end
    chk("qual_resp_count", 32'(got), 32'h1);
    chk("qual_drops", 32'(bus.drop_cnt), 32'h0);
    send(2'd0, 3'd0, 16'hFFFF);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.sensor_req != 4'b0000 || bus.busy) bad++;
      tick();
    end
    chk("nop_activity", 32'(bad), 32'h0);
    chk("nop_drops", 32'(bus.drop_cnt), 32'h0);
    bus.sensor_ack = 4'h0;

    // Backpressure: response held while resp_ready stays low, second command waits.
    reset_dut();
    bus.resp_ready = 1'b0;
    send(2'd0, 3'd4, 16'h1234);
    send(2'd3, 3'd5, 16'h4321);
    chk("bp_req0", 32'(bus.sensor_req), 32'h1);
    bus.sensor_ack = 4'b0001; bus.sensor_rdata = 16'hCAFE;
    tick();
    bus.sensor_ack = 4'b0000; bus.sensor_rdata = 16'h0000;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid && bus.resp_data == 16'hCAFE && bus.resp_sensor == 2'd0 &&
          bus.resp_op == 3'd4 && !bus.resp_err && bus.sensor_req == 4'b0000 && bus.busy) n++;
      tick();
    end
    chk("bp_stable_cycles", 32'(n), 32'd20);
    bus.resp_ready = 1'b1;
    wait_req("bp_wait_next", 20);
    chk("bp_next_req", 32'(bus.sensor_req), 32'h8);
    chk("bp_next_op", 32'(bus.sensor_op), 32'h5);
    chk("bp_next_wdata", 32'(bus.sensor_wdata), 32'h4321);

    // Reset with one command in flight and two queued.
    send(2'd1, 3'd6, 16'hAAAA);
    send(2'd2, 3'd7, 16'hBBBB);
    chk("rst_pre_req", 32'(bus.sensor_req), 32'h8);
    reset = 1'b1;
    tick();
    chk("rst_req", 32'(bus.sensor_req), 32'h0);
    chk("rst_sop", 32'(bus.sensor_op), 32'h0);
    chk("rst_swd", 32'(bus.sensor_wdata), 32'h0);
    chk("rst_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_rdata", 32'(bus.resp_data), 32'h0);
    chk("rst_rop", 32'(bus.resp_op), 32'h0);
    chk("rst_full", 32'(bus.cmd_full), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.sensor_req != 4'b0000 || bus.busy) bad++;
      tick();
    end
    chk("rst_quiet", 32'(bad), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.data_rdy     = ($urandom_range(0, 1) == 1);
      bus.sensor_num   = 2'($urandom_range(0, 3));
      bus.op_code      = 3'($urandom_range(0, 7));
      bus.data_in      = 16'($urandom);
      bus.sensor_ack   = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      bus.sensor_rdata = 16'($urandom);
      bus.resp_ready   = ($urandom_range(0, 9) < 7);
      reset            = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    bus.data_rdy = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_op_sched.md
# sensor_op_sched

Command scheduler between `decode_op` and the four sensor interfaces of the RFID tag. It buffers decoded operations (`sensor_num`, `op_code`, operand) in a small FIFO and issues them one at a time to the addressed sensor over a request/acknowledge handshake, applying a timeout. It returns each result, or an error on timeout, to the response consumer over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4, command FIFO depth; power of 2, minimum 2.
- `TIMEOUT`, 255, cycles a sensor request is held before being declared failed; range 1..65535.

Ports:
- `clock` in 1: single clock domain; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_rdy` in 1: command-valid from `decode_op`; edge-qualified, see Operation.
- `sensor_num` in 2: target sensor index 0..3.
- `op_code` in 3: operation; 3'b000 is NOP.
- `data_in` in 16: operand (`decode_op` `data_out`).
- `cmd_full` out 1: FIFO holds `DEPTH` entries.
- `sensor_req` out 4: one-hot request to sensor n.
- `sensor_op` out 3: op_code of the in-flight command.
- `sensor_wdata` out 16: operand of the in-flight command.
- `sensor_ack` in 4: per-sensor acknowledge.
- `sensor_rdata` in 16: shared read bus, valid when the granted sensor acks.
- `resp_valid` out 1: response available.
- `resp_sensor` out 2, `resp_op` out 3, `resp_data` out 16, `resp_err` out 1: response fields.
- `resp_ready` in 1: consumer accepts response.
- `busy` out 1: state != IDLE or FIFO non-empty.
- `drop_cnt` out 8: saturating count of commands dropped because the FIFO was full.

## Operation
- Enqueue strobe: `data_rdy` is high this cycle and was low the previous cycle. The registered previous value resets to 0, so `data_rdy` high at the first cycle after reset counts as an edge.
- On a strobe with `op_code`==000: ignored. Not enqueued, not counted.
- On a strobe with any other op: enqueue {`sensor_num`, `op_code`, `data_in`} if count<`DEPTH`, or if a pop occurs on the same edge. Otherwise drop the command and increment `drop_cnt`, saturating at 255.
- FIFO pointers wrap modulo `DEPTH`. Count runs 0..`DEPTH`.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into command registers, clear the timer, go to REQ.
  - REQ: `sensor_req[sensor]`=1; `sensor_op` and `sensor_wdata` are driven from the command registers.
    - If `sensor_ack[sensor]`=1: capture `sensor_rdata` into `resp_data`, set `resp_err`=0, go to RESP.
    - Else if timer==`TIMEOUT`-1: set `resp_data`=0, `resp_err`=1, go to RESP.
    - Else increment the timer.
    - Acks from non-addressed sensors are ignored.
  - RESP: `resp_valid`=1. Hold all `resp_*` fields stable until `resp_ready`=1, then go to IDLE.
- Ack and timeout on the same edge: ack wins.
- All outputs are registered.
- `sensor_req` is all-zero outside REQ. `sensor_op` and `sensor_wdata` hold their last value.

## Timing
- Reset values:
  - `sensor_req`=0, `sensor_op`=0, `sensor_wdata`=0.
  - `resp_valid`=0, `resp_sensor`=0, `resp_op`=0, `resp_data`=0, `resp_err`=0.
  - `cmd_full`=0, `busy`=0, `drop_cnt`=0.
  - FIFO empty, state IDLE.
- Latency with an empty FIFO: strobe sampled at edge E0 → entry written at E0 → pop at E1 → `sensor_req` high from E1. This is 1 cycle after enqueue.
- Ack sampled at edge Ea → `resp_valid` high from Ea; `sensor_req` low from Ea.
- An ack present in the first REQ cycle is honored; the minimum REQ duration is 1 cycle.
- Timeout: `sensor_req` is held exactly `TIMEOUT` cycles, then `resp_valid`=1 with `resp_err`=1.
- Response handshake: transfer occurs at an edge with `resp_valid`&`resp_ready`. IDLE follows that edge. The next pop happens no earlier than the edge after it, giving a minimum 1 IDLE cycle between commands.
- `cmd_full` and `busy` reflect post-edge state.
- Reset mid-operation (any state) clears everything on the next edge:
  - The in-flight request is abandoned; `sensor_req` drops at that edge.
  - Any pending response is lost.
  - Queued commands are discarded.

## Test plan
- Single read: reset, strobe {sensor 2, op 3'b001, 16'h0005}. Sensor 2 acks after 3 cycles with `sensor_rdata`=16'hBEEF. Expect `sensor_req`=4'b0100 for 3 cycles, then `resp_valid`=1 with `resp_sensor`=2, `resp_op`=1, `resp_data`=16'hBEEF, `resp_err`=0.
- Timeout: `TIMEOUT`=8, strobe for sensor 1, no ack. Expect `sensor_req`=4'b0010 for exactly 8 cycles, then `resp_err`=1 and `resp_data`=0.
- Overflow: `DEPTH`=4, stall sensors with no ack, issue 7 non-NOP strobes. Expect 1 command in flight, 4 queued, `cmd_full`=1, `drop_cnt`=2. Then ack all; expect 5 responses in enqueue order.
- Strobe qualification: hold `data_rdy` high for 10 cycles with op=2 → exactly 1 command. A strobe with op=0 → no `sensor_req`, `drop_cnt` unchanged.
- Backpressure: hold `resp_ready`=0 for 20 cycles after an ack. Expect `resp_*` stable, no new `sensor_req`, queue retained.
- Reset mid-REQ: with 2 queued commands plus 1 in flight, assert `reset` for 1 cycle. Expect all outputs at reset values at the next edge, `busy`=0, and no further `sensor_req`.
